fire_arbiter: RTL and testbench
===============================

FIRE_ARBITER -- requirements
Module: fire_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of fire requesters.
REQ-002 SHALL have parameter IDX_W, default 12, synapse index width.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  run qualifier; low freezes all state.
REQ-006 SHALL have port req_vld  input  NUM_REQ  per-requester range valid.
REQ-007 SHALL have port req_start_0..3  input  IDX_W each  first synapse index per requester.
REQ-008 SHALL have port req_end_0..3  input  IDX_W each  last synapse index per requester, inclusive.
REQ-009 SHALL have port req_rdy  output  NUM_REQ  per-requester accept.
REQ-010 SHALL have port out_start  output  IDX_W  granted range start, to dispatcher.
REQ-011 SHALL have port out_end  output  IDX_W  granted range end, to dispatcher.
REQ-012 SHALL have port out_vld  output  1  granted range valid.
REQ-013 SHALL have port out_rdy  input  1  dispatcher accepts range.
REQ-014 SHALL have port dispatch_done  input  1  dispatcher idle, no synapses in flight.
REQ-015 SHALL have port step_done  output  1  arbiter and dispatcher fully drained.
REQ-016 SHALL have port range_err  output  1  sticky flag: malformed range dropped.
REQ-017 SHALL have port err_src  output  2  requester index of first malformed range.

Function
REQ-018 SHALL hold one registered output entry (out_start, out_end, out_vld).
REQ-019 SHALL treat the entry as loadable when out_vld=0 or (out_vld & out_rdy).
REQ-020 SHALL, when enable=1 and entry loadable, select one winner among asserted req_vld by round-robin from pointer rr_ptr.
REQ-021 SHALL drive req_rdy combinationally high only for the winner; all other bits 0; all bits 0 when enable=0 or not loadable.
REQ-022 SHALL transfer on req_vld[i] & req_rdy[i]; entry loads winner's start/end next edge; latency request-to-out_vld one cycle.
REQ-023 SHALL set rr_ptr to (winner+1) mod NUM_REQ on each transfer; unchanged otherwise.
REQ-024 SHALL sustain one transfer per cycle while out_rdy=1 and requests pending.
REQ-025 SHALL clear out_vld on out_vld & out_rdy with no new transfer that cycle.
REQ-026 SHALL keep out_start/out_end stable while out_vld=1 and out_rdy=0.
REQ-027 SHALL accept but not forward a range with start > end; set range_err, and capture err_src only if range_err was 0.
REQ-028 SHALL forward start = end as a valid single-synapse range.
REQ-029 SHALL, with enable=0, hold all state; out_vld stays asserted if set, and out_rdy is ignored.
REQ-030 SHALL register step_done = enable & no req_vld & out_vld=0 & dispatch_done, one cycle delay.
REQ-031 SHALL keep range_err set until reset.

Reset
REQ-032 SHALL on reset clear out_vld, out_start, out_end, rr_ptr, range_err, and err_src to 0, and step_done to 0.
REQ-033 SHALL let reset override enable; any in-flight entry is discarded; req_rdy=0 during reset.

Structure
REQ-034 SHALL take IDX_W, NUM_REQ, and the requester-index type from the shared ucaspian package.
REQ-035 SHALL place round-robin selection in sub-module rr_select (inputs: request vector, pointer; outputs: one-hot grant, any).

Verification
REQ-036 SHALL cover: req_vld=4'b1111, out_rdy=1 -> grants 0,1,2,3,0 on consecutive cycles.
REQ-037 SHALL cover: req 2 start=0x400 end=0x40F, out_rdy=0 for 3 cycles -> out_vld=1, out_start=0x400 held, req_rdy=0; transfer completes on the first out_rdy=1 cycle.
REQ-038 SHALL cover: req 1 start=0x010 end=0x00F -> req_rdy[1]=1, no out_vld, range_err=1, err_src=1; a later malformed range on req 3 leaves err_src=1.
REQ-039 SHALL cover: enable=0 while out_vld=1 and out_rdy=1 -> entry held, no grants; enable=1 -> drains next cycle.
REQ-040 SHALL cover: reset asserted with out_vld=1 and rr_ptr=2 -> next cycle out_vld=0, rr_ptr=0, range_err=0.
REQ-041 SHALL cover: all req_vld=0, out_vld=0, dispatch_done=1 -> step_done=1 one cycle later; dispatch_done=0 -> step_done=0.

Source files
------------

// File: rtl/ucaspian_pkg.sv
// ucaspian_pkg
// Shared definitions for the uCaspian fire path: default requester count,
// synapse index width, the requester-index type and the round-robin pointer
// advance helper used by the fire arbiter.
package ucaspian_pkg;

    localparam int ARB_NUM_REQ = 4;
    localparam int ARB_IDX_W   = 12;
    localparam int REQ_IDX_W   = 2;

    typedef logic [REQ_IDX_W-1:0] reqIdx_t;

    // Next round-robin starting point: the requester just after the winner,
    // wrapping back to 0 after the last requester.
    function automatic reqIdx_t nextPtr(input reqIdx_t winner, input int numReq);
        if (int'(winner) >= numReq - 1) begin
            return '0;
        end
        return winner + reqIdx_t'(1);
    endfunction

endpackage

// File: rtl/rr_select.sv
// rr_select
// Purely combinational round-robin picker. Searches the request vector
// starting at ptr_i and moving upward with wrap, granting the first set bit.
// Ports:
//   req_i   - request vector, one bit per requester
//   ptr_i   - requester index with highest priority this cycle
//   grant_o - one-hot grant (all zero when nothing requests)
//   any_o   - at least one request is asserted
module rr_select
    import ucaspian_pkg::*;
#(
    parameter int N = ARB_NUM_REQ
) (
    input  logic [N-1:0]           req_i,
    input  logic [REQ_IDX_W-1:0]   ptr_i,
    output logic [N-1:0]           grant_o,
    output logic                   any_o
);

    logic [REQ_IDX_W-1:0] idx;

    // Walk the requesters in priority order from the pointer; the first hit
    // wins and blocks all later candidates.
    always_comb begin
        grant_o = '0;
        any_o   = 1'b0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            idx = REQ_IDX_W'((int'(ptr_i) + k) % N);
            if (!any_o && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                any_o        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fire_arbiter.sv
// fire_arbiter
// Merges synapse-range fire requests from several requesters into a single
// registered output entry for the dispatcher, using round-robin fairness.
// Malformed ranges (start > end) are accepted and dropped, raising a sticky
// error flag that records the first offending requester.
// Ports:
//   clk, reset          - clock and synchronous active-high reset
//   enable              - run qualifier; low freezes arbitration and the entry
//   req_vld/req_rdy     - per-requester handshake
//   req_start_N/_end_N  - inclusive synapse range offered by requester N
//   out_start/out_end   - granted range held for the dispatcher
//   out_vld/out_rdy     - output handshake with the dispatcher
//   dispatch_done       - dispatcher has nothing in flight
//   step_done           - arbiter and dispatcher fully drained (registered)
//   range_err/err_src   - sticky malformed-range flag and first source
module fire_arbiter
    import ucaspian_pkg::*;
#(
    parameter int NUM_REQ = ARB_NUM_REQ,
    parameter int IDX_W   = ARB_IDX_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [NUM_REQ-1:0]   req_vld,
    input  logic [IDX_W-1:0]     req_start_0,
    input  logic [IDX_W-1:0]     req_start_1,
    input  logic [IDX_W-1:0]     req_start_2,
    input  logic [IDX_W-1:0]     req_start_3,
    input  logic [IDX_W-1:0]     req_end_0,
    input  logic [IDX_W-1:0]     req_end_1,
    input  logic [IDX_W-1:0]     req_end_2,
    input  logic [IDX_W-1:0]     req_end_3,
    output logic [NUM_REQ-1:0]   req_rdy,
    output logic [IDX_W-1:0]     out_start,
    output logic [IDX_W-1:0]     out_end,
    output logic                 out_vld,
    input  logic                 out_rdy,
    input  logic                 dispatch_done,
    output logic                 step_done,
    output logic                 range_err,
    output logic [1:0]           err_src
);

    logic [IDX_W-1:0]   reqStart [4];
    logic [IDX_W-1:0]   reqEnd   [4];

    logic [NUM_REQ-1:0] grant;
    logic               grantAny;
    logic               canGrant;
    logic               transfer;
    reqIdx_t            winnerIdx;
    logic [IDX_W-1:0]   winStart;
    logic [IDX_W-1:0]   winEnd;
    logic               malformed;

    logic               outVld_q,   outVld_d;
    logic [IDX_W-1:0]   outStart_q, outStart_d;
    logic [IDX_W-1:0]   outEnd_q,   outEnd_d;
    reqIdx_t            rrPtr_q,    rrPtr_d;
    logic               rangeErr_q, rangeErr_d;
    reqIdx_t            errSrc_q,   errSrc_d;
    logic               stepDone_q, stepDone_d;

    assign reqStart[0] = req_start_0;
    assign reqStart[1] = req_start_1;
    assign reqStart[2] = req_start_2;
    assign reqStart[3] = req_start_3;
    assign reqEnd[0]   = req_end_0;
    assign reqEnd[1]   = req_end_1;
    assign reqEnd[2]   = req_end_2;
    assign reqEnd[3]   = req_end_3;

    rr_select #(
        .N(NUM_REQ)
    ) uRrSelect (
        .req_i   (req_vld),
        .ptr_i   (rrPtr_q),
        .grant_o (grant),
        .any_o   (grantAny)
    );

    // The entry can take a new range when empty or when it is being drained
    // this same cycle; reset suppresses every grant.
    assign canGrant = enable && !reset && (!outVld_q || out_rdy);
    assign req_rdy  = canGrant ? grant : '0;
    assign transfer = canGrant && grantAny;

    // Convert the one-hot grant into a requester index.
    always_comb begin
        winnerIdx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                winnerIdx = reqIdx_t'(i);
            end
        end
    end

    assign winStart  = reqStart[winnerIdx];
    assign winEnd    = reqEnd[winnerIdx];
    assign malformed = winStart > winEnd;

    // Next-state: a well-formed transfer loads the entry; a malformed one is
    // consumed without loading, but still lets a drained entry empty out.
    always_comb begin
        outVld_d   = outVld_q;
        outStart_d = outStart_q;
        outEnd_d   = outEnd_q;
        rrPtr_d    = rrPtr_q;
        rangeErr_d = rangeErr_q;
        errSrc_d   = errSrc_q;
        stepDone_d = enable && !(|req_vld) && !outVld_q && dispatch_done;
        if (enable) begin
            if (transfer) begin
                rrPtr_d = nextPtr(winnerIdx, NUM_REQ);
                if (malformed) begin
                    rangeErr_d = 1'b1;
                    if (!rangeErr_q) begin
                        errSrc_d = winnerIdx;
                    end
                    if (outVld_q && out_rdy) begin
                        outVld_d = 1'b0;
                    end
                end else begin
                    outVld_d   = 1'b1;
                    outStart_d = winStart;
                    outEnd_d   = winEnd;
                end
            end else if (outVld_q && out_rdy) begin
                outVld_d = 1'b0;
            end
        end
    end

    // State register; reset discards any in-flight entry and the error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            outVld_q   <= 1'b0;
            outStart_q <= '0;
            outEnd_q   <= '0;
            rrPtr_q    <= '0;
            rangeErr_q <= 1'b0;
            errSrc_q   <= '0;
            stepDone_q <= 1'b0;
        end else begin
            outVld_q   <= outVld_d;
            outStart_q <= outStart_d;
            outEnd_q   <= outEnd_d;
            rrPtr_q    <= rrPtr_d;
            rangeErr_q <= rangeErr_d;
            errSrc_q   <= errSrc_d;
            stepDone_q <= stepDone_d;
        end
    end

    assign out_vld   = outVld_q;
    assign out_start = outStart_q;
    assign out_end   = outEnd_q;
    assign range_err = rangeErr_q;
    assign err_src   = errSrc_q;
    assign step_done = stepDone_q;

endmodule

// File: tb/tb_fire_arbiter.sv
// tb_fire_arbiter
// Self-checking bench for fire_arbiter: directed scenarios for round-robin
// order, back-pressure, malformed ranges, enable freeze, reset and step_done,
// followed by randomized traffic compared against a cycle-level reference
// model of the arbitration rules.
module tb_fire_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [3:0]  req_vld;
    logic [11:0] req_start_0, req_start_1, req_start_2, req_start_3;
    logic [11:0] req_end_0, req_end_1, req_end_2, req_end_3;
    logic [3:0]  req_rdy;
    logic [11:0] out_start;
    logic [11:0] out_end;
    logic        out_vld;
    logic        out_rdy;
    logic        dispatch_done;
    logic        step_done;
    logic        range_err;
    logic [1:0]  err_src;

    int nChecks = 0;
    int nFails  = 0;

    // Reference model state
    logic        mVld   = 1'b0;
    logic [11:0] mStart = '0;
    logic [11:0] mEnd   = '0;
    int          mPtr   = 0;
    logic        mErr   = 1'b0;
    logic [1:0]  mSrc   = '0;
    logic        mStep  = 1'b0;
    logic [3:0]  lastRdy;

    always #5 clk = ~clk;

    fire_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .req_vld       (req_vld),
        .req_start_0   (req_start_0),
        .req_start_1   (req_start_1),
        .req_start_2   (req_start_2),
        .req_start_3   (req_start_3),
        .req_end_0     (req_end_0),
        .req_end_1     (req_end_1),
        .req_end_2     (req_end_2),
        .req_end_3     (req_end_3),
        .req_rdy       (req_rdy),
        .out_start     (out_start),
        .out_end       (out_end),
        .out_vld       (out_vld),
        .out_rdy       (out_rdy),
        .dispatch_done (dispatch_done),
        .step_done     (step_done),
        .range_err     (range_err),
        .err_src       (err_src)
    );

    // Single comparison point: counts and reports every check.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic setRange(input int i, input logic [11:0] s, input logic [11:0] e);
        case (i)
            0: begin req_start_0 = s; req_end_0 = e; end
            1: begin req_start_1 = s; req_end_1 = e; end
            2: begin req_start_2 = s; req_end_2 = e; end
            default: begin req_start_3 = s; req_end_3 = e; end
        endcase
    endtask

    // One clock cycle: check the combinational accept against the model,
    // advance the model with the arbitration rules, clock, then check all
    // registered outputs.
    task automatic applyStimulus();
        logic [3:0]  expRdy;
        logic [11:0] s [4];
        logic [11:0] e [4];
        int          win;
        logic        loadable;
        #1;
        s[0] = req_start_0; s[1] = req_start_1; s[2] = req_start_2; s[3] = req_start_3;
        e[0] = req_end_0;   e[1] = req_end_1;   e[2] = req_end_2;   e[3] = req_end_3;
        loadable = !mVld || out_rdy;
        expRdy   = '0;
        win      = -1;
        if (!reset && enable && loadable) begin
            for (int k = 0; k < 4; k++) begin
                int idx;
                idx = (mPtr + k) % 4;
                if (win < 0 && req_vld[idx]) win = idx;
            end
        end
        if (win >= 0) expRdy[win] = 1'b1;
        lastRdy = req_rdy;
        checkOutput("req_rdy", 32'(req_rdy), 32'(expRdy));

        if (reset) begin
            mVld = 1'b0; mStart = '0; mEnd = '0; mPtr = 0;
            mErr = 1'b0; mSrc = '0; mStep = 1'b0;
        end else begin
            mStep = enable && (req_vld == 4'b0) && !mVld && dispatch_done;
            if (enable) begin
                if (win >= 0) begin
                    mPtr = (win + 1) % 4;
                    if (s[win] > e[win]) begin
                        if (!mErr) mSrc = 2'(win);
                        mErr = 1'b1;
                        if (mVld && out_rdy) mVld = 1'b0;
                    end else begin
                        mVld   = 1'b1;
                        mStart = s[win];
                        mEnd   = e[win];
                    end
                end else if (mVld && out_rdy) begin
                    mVld = 1'b0;
                end
            end
        end

        @(posedge clk);
        #1;
        checkOutput("out_vld", 32'(out_vld), 32'(mVld));
        if (mVld) begin
            checkOutput("out_start", 32'(out_start), 32'(mStart));
            checkOutput("out_end", 32'(out_end), 32'(mEnd));
        end
        checkOutput("range_err", 32'(range_err), 32'(mErr));
        checkOutput("err_src", 32'(err_src), 32'(mSrc));
        checkOutput("step_done", 32'(step_done), 32'(mStep));
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; req_vld = '0; out_rdy = 1'b0; dispatch_done = 1'b0;
        for (int i = 0; i < 4; i++) setRange(i, '0, '0);

        // Reset state
        applyStimulus();
        applyStimulus();
        checkOutput("rst_out_vld", 32'(out_vld), 32'h0);
        checkOutput("rst_out_start", 32'(out_start), 32'h0);
        checkOutput("rst_out_end", 32'(out_end), 32'h0);
        checkOutput("rst_range_err", 32'(range_err), 32'h0);
        checkOutput("rst_step_done", 32'(step_done), 32'h0);
        reset = 1'b0;

        // All requesters active, dispatcher always ready: grants rotate 0,1,2,3,0
        req_vld = 4'b1111; out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) setRange(i, 12'(i * 256), 12'(i * 256 + 15));
        for (int c = 0; c < 5; c++) begin
            logic [3:0] oneHot;
            oneHot = 4'b0001 << (c % 4);
            applyStimulus();
            checkOutput("rr_grant", 32'(lastRdy), 32'(oneHot));
            checkOutput("rr_out_start", 32'(out_start), 32'((c % 4) * 256));
        end

        // Back-pressure on a single requester
        req_vld = 4'b0000; out_rdy = 1'b1;
        applyStimulus();
        req_vld = 4'b0100; out_rdy = 1'b0;
        setRange(2, 12'h400, 12'h40F);
        applyStimulus();
        checkOutput("bp_first_rdy", 32'(lastRdy), 32'h4);
        for (int c = 0; c < 3; c++) begin
            applyStimulus();
            checkOutput("bp_hold_rdy", 32'(lastRdy), 32'h0);
            checkOutput("bp_hold_vld", 32'(out_vld), 32'h1);
            checkOutput("bp_hold_start", 32'(out_start), 32'h400);
        end
        out_rdy = 1'b1;
        applyStimulus();
        checkOutput("bp_release_rdy", 32'(lastRdy), 32'h4);

        // Malformed ranges: first one records its source, later ones do not
        req_vld = 4'b0000; out_rdy = 1'b1;
        applyStimulus();
        req_vld = 4'b0010;
        setRange(1, 12'h010, 12'h00F);
        applyStimulus();
        checkOutput("bad_rdy", 32'(lastRdy), 32'h2);
        checkOutput("bad_out_vld", 32'(out_vld), 32'h0);
        checkOutput("bad_range_err", 32'(range_err), 32'h1);
        checkOutput("bad_err_src", 32'(err_src), 32'h1);
        req_vld = 4'b1000;
        setRange(3, 12'h300, 12'h2FF);
        applyStimulus();
        checkOutput("bad2_rdy", 32'(lastRdy), 32'h8);
        checkOutput("bad2_err_src", 32'(err_src), 32'h1);

        // Enable low freezes a full entry even with the dispatcher ready
        req_vld = 4'b0001; out_rdy = 1'b0;
        setRange(0, 12'h123, 12'h130);
        applyStimulus();
        enable = 1'b0; out_rdy = 1'b1; req_vld = 4'b1111;
        for (int c = 0; c < 2; c++) begin
            applyStimulus();
            checkOutput("frz_rdy", 32'(lastRdy), 32'h0);
            checkOutput("frz_vld", 32'(out_vld), 32'h1);
            checkOutput("frz_start", 32'(out_start), 32'h123);
        end
        enable = 1'b1; req_vld = 4'b0000;
        applyStimulus();
        checkOutput("frz_drain_vld", 32'(out_vld), 32'h0);

        // Reset with a full entry and pointer at 2
        req_vld = 4'b0010; out_rdy = 1'b0;
        setRange(1, 12'h050, 12'h060);
        applyStimulus();
        reset = 1'b1; req_vld = 4'b1111;
        applyStimulus();
        checkOutput("rst2_rdy", 32'(lastRdy), 32'h0);
        checkOutput("rst2_out_vld", 32'(out_vld), 32'h0);
        checkOutput("rst2_range_err", 32'(range_err), 32'h0);
        reset = 1'b0; out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) setRange(i, 12'h000, 12'h001);
        applyStimulus();
        checkOutput("rst2_ptr_grant", 32'(lastRdy), 32'h1);

        // step_done follows the drained condition by one cycle
        req_vld = 4'b0000; out_rdy = 1'b1; dispatch_done = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("step_done_hi", 32'(step_done), 32'h1);
        dispatch_done = 1'b0;
        applyStimulus();
        checkOutput("step_done_lo", 32'(step_done), 32'h0);

        // Randomized traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            reset         = ($urandom_range(0, 63) == 0);
            enable        = ($urandom_range(0, 7) != 0);
            req_vld       = 4'($urandom);
            out_rdy       = 1'($urandom_range(0, 1));
            dispatch_done = 1'($urandom_range(0, 1));
            for (int i = 0; i < 4; i++) begin
                logic [11:0] s, e, t;
                s = 12'($urandom);
                e = 12'($urandom);
                if ($urandom_range(0, 7) != 0 && e < s) begin
                    t = s; s = e; e = t;
                end
                if ($urandom_range(0, 15) == 0) e = s;
                setRange(i, s, e);
            end
            applyStimulus();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
